// File: rtl/icache_responder.sv
// Direct-mapped, two-word-block instruction cache answering datapath fetches
// in the same cycle on a hit and refilling from memory on a miss.
module icache_responder #(
    parameter int SETS = 8,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int TAG_W = 32 - 3 - IDX_W;

    typedef enum logic [1:0] {IDLE, FETCH0, FETCH1} state_t;

    state_t             state_reg, state_next;
    logic [TAG_W-1:0]   miss_tag_reg;
    logic [IDX_W-1:0]   miss_idx_reg;
    logic               flush_pending_reg;
    logic [31:0]        hit_count_reg, miss_count_reg;

    logic [SETS-1:0]    valid_reg;
    logic [TAG_W-1:0]   tag_mem  [SETS];
    logic [31:0]        data_mem [SETS][2];

    logic               req_offset;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               unused_addr_bits;

    logic               line_match;
    logic               miss_start;
    logic               word_accept;
    logic               fill_done;
    logic               clear_all;

    assign req_offset       = imemaddr[2];
    assign req_idx          = imemaddr[2+IDX_W:3];
    assign req_tag          = imemaddr[31:3+IDX_W];
    assign unused_addr_bits = ^imemaddr[1:0];

    assign line_match  = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
    assign miss_start  = (state_reg == IDLE) && imemREN && !line_match;
    assign word_accept = (state_reg != IDLE) && !iwait;
    assign fill_done   = (state_reg == FETCH1) && !iwait;
    // A flush seen at any point of a fill also wipes the line being filled.
    assign clear_all   = ((state_reg == IDLE) && flush)
                       || (fill_done && (flush_pending_reg || flush));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (miss_start) state_next = FETCH0;
            FETCH0:  if (!iwait)     state_next = FETCH1;
            FETCH1:  if (!iwait)     state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        ihit     = 1'b0;
        imemload = 32'd0;
        iREN     = 1'b0;
        iaddr    = 32'd0;
        case (state_reg)
            IDLE: begin
                ihit     = imemREN && line_match;
                imemload = data_mem[req_idx][req_offset];
            end
            FETCH0: begin
                iREN  = 1'b1;
                iaddr = {miss_tag_reg, miss_idx_reg, 1'b0, 2'b00};
            end
            FETCH1: begin
                iREN  = 1'b1;
                iaddr = {miss_tag_reg, miss_idx_reg, 1'b1, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            miss_tag_reg      <= '0;
            miss_idx_reg      <= '0;
            flush_pending_reg <= 1'b0;
            hit_count_reg     <= 32'd0;
            miss_count_reg    <= 32'd0;
        end else begin
            if (miss_start) begin
                miss_tag_reg   <= req_tag;
                miss_idx_reg   <= req_idx;
                miss_count_reg <= miss_count_reg + 32'd1;
            end
            if (ihit) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (fill_done) begin
                flush_pending_reg <= 1'b0;
            end else if ((state_reg != IDLE) && flush) begin
                flush_pending_reg <= 1'b1;
            end
        end
    end

    // Valid is only raised when the second word lands, so a half-filled line never hits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_reg <= '0;
        end else if (clear_all) begin
            valid_reg <= '0;
        end else if (fill_done) begin
            valid_reg[miss_idx_reg] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (word_accept) begin
            data_mem[miss_idx_reg][state_reg == FETCH1] <= iload;
        end
        if (fill_done) begin
            tag_mem[miss_idx_reg] <= miss_tag_reg;
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboarded bench for icache_responder: a memory model serves fills and
// expected fill addresses / hit data are queued ahead of the traffic.
module tb_icache_responder;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int passed;
    int total;
    int wait_cfg;
    int wait_left;
    int hit_during_fill;

    logic [31:0] exp_fetch[$];
    logic [31:0] exp_data[$];

    icache_responder #(.SETS(8)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .ihit(ihit),
        .imemload(imemload),
        .flush(flush),
        .iREN(iREN),
        .iaddr(iaddr),
        .iwait(iwait),
        .iload(iload),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // One cycle: drive at the falling edge, let the memory model answer, then
    // score whatever the cache produced before the next rising edge.
    task automatic step(input logic ren, input logic [31:0] addr, input logic fl);
        logic [31:0] e;
        @(negedge CLK);
        imemREN  = ren;
        imemaddr = addr;
        flush    = fl;
        #1;
        iwait = iREN && (wait_left > 0);
        iload = iREN ? mem_word(iaddr) : 32'hDEAD_BEEF;
        #1;
        if (ihit && iREN) hit_during_fill++;
        if (iREN) begin
            total++;
            if (exp_fetch.size() == 0) begin
                $display("FAIL fetch_addr: unexpected iREN with iaddr=%h, none required", iaddr);
            end else begin
                e = exp_fetch.pop_front();
                if (iaddr !== e) $display("FAIL fetch_addr: got %h required %h", iaddr, e);
                else passed++;
            end
            if (wait_left > 0) wait_left--;
            else wait_left = wait_cfg;
        end else begin
            wait_left = wait_cfg;
        end
        if (ihit) begin
            total++;
            if (exp_data.size() == 0) begin
                $display("FAIL hit_data: unexpected ihit with imemload=%h, none required", imemload);
            end else begin
                e = exp_data.pop_front();
                if (imemload !== e) $display("FAIL hit_data: got %h required %h", imemload, e);
                else passed++;
            end
        end
    endtask

    // Hold a fetch until it hits; returns cycles after the request cycle, -1 on timeout.
    task automatic fetch(input logic [31:0] addr, output int n);
        n = 0;
        step(1'b1, addr, 1'b0);
        while (!ihit && n < 40) begin
            n++;
            step(1'b1, addr, 1'b0);
        end
        if (!ihit) n = -1;
        $display("fetch addr=%h latency=%0d data=%h misses=%0d hits=%0d",
                 addr, n, imemload, miss_count, hit_count);
    endtask

    task automatic test_reset();
        step(1'b0, 32'd0, 1'b0);
        total++; if (ihit !== 1'b0) $display("FAIL reset_ihit: got %b required 0", ihit); else passed++;
        total++; if (iREN !== 1'b0) $display("FAIL reset_iren: got %b required 0", iREN); else passed++;
        total++; if (iaddr !== 32'd0) $display("FAIL reset_iaddr: got %h required 0", iaddr); else passed++;
        total++; if (hit_count !== 32'd0) $display("FAIL reset_hits: got %0d required 0", hit_count); else passed++;
        total++; if (miss_count !== 32'd0) $display("FAIL reset_misses: got %0d required 0", miss_count); else passed++;
    endtask

    task automatic test_cold_miss();
        int n;
        exp_fetch.push_back(32'h40);
        exp_fetch.push_back(32'h44);
        exp_data.push_back(mem_word(32'h40));
        fetch(32'h40, n);
        total++; if (n != 3) $display("FAIL cold_latency: got %0d required 3", n); else passed++;
        total++; if (miss_count !== 32'd1) $display("FAIL cold_misses: got %0d required 1", miss_count); else passed++;
        exp_data.push_back(mem_word(32'h44));
        step(1'b1, 32'h44, 1'b0);
        total++; if (ihit !== 1'b1) $display("FAIL cold_second_word_hit: got %b required 1", ihit); else passed++;
        total++; if (iREN !== 1'b0) $display("FAIL cold_second_word_iren: got %b required 0", iREN); else passed++;
        step(1'b0, 32'd0, 1'b0);
        total++; if (hit_count !== 32'd2) $display("FAIL cold_hits: got %0d required 2", hit_count); else passed++;
        total++; if (exp_fetch.size() != 0 || exp_data.size() != 0)
            $display("FAIL cold_drain: got %0d/%0d pending required 0/0", exp_fetch.size(), exp_data.size());
        else passed++;
    endtask

    task automatic test_wait_states();
        int n;
        logic [31:0] m0;
        m0 = miss_count;
        wait_cfg = 3;
        hit_during_fill = 0;
        for (int i = 0; i < 4; i++) exp_fetch.push_back(32'h100);
        for (int i = 0; i < 4; i++) exp_fetch.push_back(32'h104);
        exp_data.push_back(mem_word(32'h100));
        fetch(32'h100, n);
        total++; if (n != 9) $display("FAIL wait_latency: got %0d required 9", n); else passed++;
        total++; if (hit_during_fill != 0) $display("FAIL wait_hit_in_fill: got %0d required 0", hit_during_fill); else passed++;
        total++; if (miss_count - m0 !== 32'd1) $display("FAIL wait_misses: got %0d required 1", miss_count - m0); else passed++;
        total++; if (exp_fetch.size() != 0) $display("FAIL wait_drain: got %0d pending required 0", exp_fetch.size()); else passed++;
        wait_cfg = 0;
        step(1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_conflict();
        int n;
        logic [31:0] m0;
        logic [31:0] seq [3];
        seq[0] = 32'h000; seq[1] = 32'h040; seq[2] = 32'h000;
        m0 = miss_count;
        for (int i = 0; i < 3; i++) begin
            exp_fetch.push_back(seq[i]);
            exp_fetch.push_back(seq[i] + 32'd4);
            exp_data.push_back(mem_word(seq[i]));
            fetch(seq[i], n);
            total++; if (n != 3) $display("FAIL conflict_latency_%0d: got %0d required 3", i, n); else passed++;
        end
        total++; if (miss_count - m0 !== 32'd3) $display("FAIL conflict_misses: got %0d required 3", miss_count - m0); else passed++;
        step(1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_withdraw();
        logic [31:0] m0;
        m0 = miss_count;
        exp_fetch.push_back(32'h80);
        exp_fetch.push_back(32'h84);
        step(1'b1, 32'h80, 1'b0);
        step(1'b1, 32'h80, 1'b0);
        step(1'b0, 32'h0000_0F00, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        total++; if (iREN !== 1'b0) $display("FAIL withdraw_idle: got iREN=%b required 0", iREN); else passed++;
        exp_data.push_back(mem_word(32'h84));
        step(1'b1, 32'h84, 1'b0);
        total++; if (ihit !== 1'b1) $display("FAIL withdraw_hit: got %b required 1", ihit); else passed++;
        total++; if (iREN !== 1'b0) $display("FAIL withdraw_iren: got %b required 0", iREN); else passed++;
        total++; if (miss_count - m0 !== 32'd1) $display("FAIL withdraw_misses: got %0d required 1", miss_count - m0); else passed++;
        step(1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_flush();
        int n;
        logic [31:0] m0;
        m0 = miss_count;
        for (int i = 0; i < 3; i++) begin
            exp_fetch.push_back(32'h200);
            exp_fetch.push_back(32'h204);
        end
        step(1'b1, 32'h200, 1'b0);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        exp_data.push_back(mem_word(32'h200));
        fetch(32'h200, n);
        total++; if (n != 3) $display("FAIL flush_fill_refetch: got latency %0d required 3", n); else passed++;
        total++; if (miss_count - m0 !== 32'd2) $display("FAIL flush_fill_misses: got %0d required 2", miss_count - m0); else passed++;
        exp_data.push_back(mem_word(32'h200));
        step(1'b1, 32'h200, 1'b1);
        total++; if (ihit !== 1'b1) $display("FAIL flush_same_cycle_hit: got %b required 1", ihit); else passed++;
        exp_data.push_back(mem_word(32'h200));
        fetch(32'h200, n);
        total++; if (n != 3) $display("FAIL flush_idle_refetch: got latency %0d required 3", n); else passed++;
        total++; if (miss_count - m0 !== 32'd3) $display("FAIL flush_idle_misses: got %0d required 3", miss_count - m0); else passed++;
        step(1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_reset_mid_fill();
        int n;
        exp_fetch.push_back(32'h300);
        exp_fetch.push_back(32'h304);
        step(1'b1, 32'h300, 1'b0);
        step(1'b1, 32'h300, 1'b0);
        step(1'b1, 32'h300, 1'b0);
        total++; if (iREN !== 1'b1 || iaddr !== 32'h304)
            $display("FAIL rst_in_fetch1: got iREN=%b iaddr=%h required 1/00000304", iREN, iaddr);
        else passed++;
        #2 nRST = 1'b0;
        #1;
        total++; if (iREN !== 1'b0) $display("FAIL rst_async_iren: got %b required 0", iREN); else passed++;
        total++; if (hit_count !== 32'd0 || miss_count !== 32'd0)
            $display("FAIL rst_async_counts: got %0d/%0d required 0/0", hit_count, miss_count);
        else passed++;
        imemREN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        exp_fetch.push_back(32'h300);
        exp_fetch.push_back(32'h304);
        exp_data.push_back(mem_word(32'h300));
        fetch(32'h300, n);
        total++; if (n != 3) $display("FAIL rst_refetch: got latency %0d required 3", n); else passed++;
        total++; if (miss_count !== 32'd1) $display("FAIL rst_misses: got %0d required 1", miss_count); else passed++;
        total++; if (exp_fetch.size() != 0 || exp_data.size() != 0)
            $display("FAIL final_drain: got %0d/%0d pending required 0/0", exp_fetch.size(), exp_data.size());
        else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        passed = 0;
        total = 0;
        wait_cfg = 0;
        wait_left = 0;
        hit_during_fill = 0;
        nRST = 1'b0;
        imemREN = 1'b0;
        imemaddr = 32'd0;
        flush = 1'b0;
        iwait = 1'b0;
        iload = 32'd0;
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        test_reset();
        test_cold_miss();
        test_wait_states();
        test_conflict();
        test_withdraw();
        test_flush();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
